// File: rtl/sys_cntr_tx_mb.sv
// Multi-byte response sender: queues read/ALU responses and serialises them LSB-first,
// launching each byte with a toggle on Tx_Data_valid. Optional macro: TX_TIMEOUT_EN.
module sys_cntr_tx_mb #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ALU_BYTES   = 2,
  parameter int unsigned Q_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                        CLK,
  input  logic                        Reset,
  input  logic [WIDTH-1:0]            RdData,
  input  logic                        Rd_valid,
  input  logic [ALU_BYTES*WIDTH-1:0]  ALU_out,
  input  logic                        ALU_out_valid,
  input  logic [3:0]                  ALU_FUN,
  input  logic                        Busy,
  input  logic                        Ser_done,
  output logic [WIDTH-1:0]            Tx_Data,
  output logic                        Tx_Data_valid,
  output logic [$clog2(Q_DEPTH):0]    Q_count,
  output logic                        Ovf,
  output logic                        Err
);

  localparam int unsigned PW  = ALU_BYTES * WIDTH;
  localparam int unsigned NBW = $clog2(ALU_BYTES + 1);
  localparam int unsigned AW  = $clog2(Q_DEPTH);
  localparam int unsigned CW  = AW + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  logic [PW-1:0]  pay_q [Q_DEPTH];
  logic [NBW-1:0] nb_q  [Q_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q;

  state_t         state_q;
  logic [PW-1:0]  shift_q;
  logic [NBW-1:0] bcnt_q;
  logic [WIDTH-1:0] tx_data_q;
  logic           tx_tgl_q;

  logic           full, enq_req, enq_ok, drop, pop;
  logic [PW-1:0]  enq_pay;
  logic [NBW-1:0] enq_nb;
  logic [1:0]     unused_fun;

  assign unused_fun = ALU_FUN[1:0];

  assign full    = (count_q == CW'(Q_DEPTH));
  assign pop     = (state_q == IDLE) && (count_q != '0) && !Busy;
  assign enq_req = Rd_valid | ALU_out_valid;
  // A full queue still accepts when the head leaves in the same cycle.
  assign enq_ok  = enq_req && (!full || pop);
  assign drop    = (Rd_valid && ALU_out_valid) || (enq_req && !enq_ok);
  assign count_d = count_q + CW'(enq_ok) - CW'(pop);

  always_comb begin
    enq_pay = ALU_out;
    enq_nb  = NBW'(1);
    if (Rd_valid) begin
      enq_pay = PW'(RdData);
    end else if (ALU_FUN[3:2] == 2'b00) begin
      enq_nb = NBW'(ALU_BYTES);
    end
  end

  always_ff @(posedge CLK) begin
    if (enq_ok) begin
      pay_q[wr_ptr_q] <= enq_pay;
      nb_q[wr_ptr_q]  <= enq_nb;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (enq_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (drop)   ovf_q <= 1'b1;
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;
  logic          tmo_hit;
  // Abort on the TIMEOUT_CYC-th edge spent in the same wait state.
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign Err     = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC == 0);
  assign Err        = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bcnt_q    <= '0;
      tx_data_q <= '0;
      tx_tgl_q  <= 1'b0;
`ifdef TX_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
`ifdef TX_TIMEOUT_EN
      tmo_q <= '0;
`endif
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= pay_q[rd_ptr_q];
            bcnt_q  <= nb_q[rd_ptr_q];
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_data_q <= shift_q[WIDTH-1:0];
          tx_tgl_q  <= ~tx_tgl_q;
          shift_q   <= shift_q >> WIDTH;
          bcnt_q    <= bcnt_q - NBW'(1);
          state_q   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (Busy) state_q <= WAIT_DONE;
`ifdef TX_TIMEOUT_EN
          else if (tmo_hit) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            err_q   <= 1'b1;
          end else tmo_q <= tmo_q + TW'(1);
`endif
        end
        WAIT_DONE: begin
          if (Ser_done) state_q <= (bcnt_q != '0) ? LAUNCH : IDLE;
`ifdef TX_TIMEOUT_EN
          else if (tmo_hit) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            err_q   <= 1'b1;
          end else tmo_q <= tmo_q + TW'(1);
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Tx_Data       = tx_data_q;
  assign Tx_Data_valid = tx_tgl_q;
  assign Q_count       = count_q;
  assign Ovf           = ovf_q;

endmodule

// File: tb/tb_sys_cntr_tx_mb.sv
// Scoreboard bench for sys_cntr_tx_mb: expected bytes are queued at stimulus time and
// popped on each Tx_Data_valid toggle. Timeout scenario runs when TX_TIMEOUT_EN is defined.
module tb_sys_cntr_tx_mb;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  RdData = '0;
  logic        Rd_valid = 1'b0;
  logic [15:0] ALU_out = '0;
  logic        ALU_out_valid = 1'b0;
  logic [3:0]  ALU_FUN = '0;
  logic        Busy = 1'b0;
  logic        Ser_done = 1'b0;
  logic [7:0]  Tx_Data;
  logic        Tx_Data_valid;
  logic [2:0]  Q_count;
  logic        Ovf;
  logic        Err;

  int total = 0;
  int bad = 0;
  int tcount = 0;
  int seen = 0;
  logic [7:0] exp_q[$];

  sys_cntr_tx_mb #(
    .WIDTH(8), .ALU_BYTES(2), .Q_DEPTH(4), .TIMEOUT_CYC(16)
  ) dut (
    .CLK(CLK), .Reset(Reset), .RdData(RdData), .Rd_valid(Rd_valid),
    .ALU_out(ALU_out), .ALU_out_valid(ALU_out_valid), .ALU_FUN(ALU_FUN),
    .Busy(Busy), .Ser_done(Ser_done), .Tx_Data(Tx_Data),
    .Tx_Data_valid(Tx_Data_valid), .Q_count(Q_count), .Ovf(Ovf), .Err(Err)
  );

  always #5 CLK = ~CLK;

  always @(Tx_Data_valid) if (!Reset) tcount++;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic pulse_rd(input logic [7:0] d);
    RdData = d; Rd_valid = 1'b1;
    @(negedge CLK);
    Rd_valid = 1'b0;
  endtask

  task automatic pulse_alu(input logic [15:0] d, input logic [3:0] fun);
    ALU_out = d; ALU_FUN = fun; ALU_out_valid = 1'b1;
    @(negedge CLK);
    ALU_out_valid = 1'b0;
  endtask

  task automatic finish_byte();
    Busy = 1'b1;
    @(negedge CLK);
    Ser_done = 1'b1;
    @(negedge CLK);
    Ser_done = 1'b0; Busy = 1'b0;
  endtask

  task automatic wait_byte(input string nm);
    int k = 0;
    logic [7:0] e;
    while (tcount == seen && k < 60) begin
      @(negedge CLK);
      k++;
    end
    total++;
    if (tcount == seen) begin
      bad++;
      $display("FAIL %s: got no launch, required a byte launch", nm);
    end else begin
      seen++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s: got unexpected byte %h, required none", nm, Tx_Data);
      end else begin
        e = exp_q.pop_front();
        if (Tx_Data !== e) begin
          bad++;
          $display("FAIL %s: got %h required %h", nm, Tx_Data, e);
        end
      end
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; Busy = 1'b0; Ser_done = 1'b0;
    tick(2);
    Reset = 1'b0;
    exp_q.delete();
    seen = tcount;
  endtask

  task automatic test_reset();
    do_reset();
    total += 5;
    if (Tx_Data !== 8'h00)    begin bad++; $display("FAIL rst_txdata: got %h required 00", Tx_Data); end
    if (Tx_Data_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", Tx_Data_valid); end
    if (Q_count !== 3'd0)     begin bad++; $display("FAIL rst_qcount: got %0d required 0", Q_count); end
    if (Ovf !== 1'b0)         begin bad++; $display("FAIL rst_ovf: got %b required 0", Ovf); end
    if (Err !== 1'b0)         begin bad++; $display("FAIL rst_err: got %b required 0", Err); end
  endtask

  task automatic test_register_read();
    exp_q.push_back(8'hA5);
    pulse_rd(8'hA5);
    total += 3;
    if (Q_count !== 3'd1) begin bad++; $display("FAIL rd_q1: got %0d required 1", Q_count); end
    if (tcount != seen) begin bad++; $display("FAIL rd_early_n: got %0d toggles required 0", tcount - seen); end
    tick(1);
    if (tcount != seen) begin bad++; $display("FAIL rd_early_n1: got %0d toggles required 0", tcount - seen); end
    tick(1);
    total++;
    if (tcount != seen + 1) begin bad++; $display("FAIL rd_latency: got %0d toggles at n+2 required 1", tcount - seen); end
    wait_byte("rd_byte");
    finish_byte();
    tick(6);
    total++;
    if (tcount != seen) begin bad++; $display("FAIL rd_extra: got %0d extra toggles required 0", tcount - seen); end
  endtask

  task automatic test_arith();
    int start = tcount;
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    pulse_alu(16'hBEEF, 4'b0000);
    wait_byte("arith_lo");
    finish_byte();
    wait_byte("arith_hi");
    finish_byte();
    tick(6);
    total++;
    if (tcount - start != 2) begin bad++; $display("FAIL arith_toggles: got %0d required 2", tcount - start); end
  endtask

  task automatic test_logic();
    int start = tcount;
    exp_q.push_back(8'h34);
    pulse_alu(16'h1234, 4'b0100);
    wait_byte("logic_byte");
    finish_byte();
    tick(6);
    total++;
    if (tcount - start != 1) begin bad++; $display("FAIL logic_toggles: got %0d required 1", tcount - start); end
  endtask

  task automatic test_overflow();
    Busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      pulse_rd(8'(i));
    end
    total += 2;
    if (Q_count !== 3'd4) begin bad++; $display("FAIL ovf_q4: got %0d required 4", Q_count); end
    if (Ovf !== 1'b0)     begin bad++; $display("FAIL ovf_early: got %b required 0", Ovf); end
    pulse_rd(8'h05);
    total += 2;
    if (Q_count !== 3'd4) begin bad++; $display("FAIL ovf_qfull: got %0d required 4", Q_count); end
    if (Ovf !== 1'b1)     begin bad++; $display("FAIL ovf_flag: got %b required 1", Ovf); end
    Busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_byte("ovf_byte");
      finish_byte();
    end
    tick(6);
    total++;
    if (Q_count !== 3'd0) begin bad++; $display("FAIL ovf_drain: got %0d required 0", Q_count); end
  endtask

  task automatic test_reset_midop();
    exp_q.push_back(8'h3C);
    pulse_rd(8'h3C);
    pulse_rd(8'h44);
    pulse_rd(8'h55);
    wait_byte("mid_first");
    Busy = 1'b1;
    tick(1);
    total++;
    if (Q_count !== 3'd2) begin bad++; $display("FAIL mid_q2: got %0d required 2", Q_count); end
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0; Busy = 1'b0;
    total += 5;
    if (Tx_Data !== 8'h00)      begin bad++; $display("FAIL mid_txdata: got %h required 00", Tx_Data); end
    if (Tx_Data_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b required 0", Tx_Data_valid); end
    if (Q_count !== 3'd0)       begin bad++; $display("FAIL mid_qcount: got %0d required 0", Q_count); end
    if (Ovf !== 1'b0)           begin bad++; $display("FAIL mid_ovf: got %b required 0", Ovf); end
    if (Err !== 1'b0)           begin bad++; $display("FAIL mid_err: got %b required 0", Err); end
    exp_q.delete();
    seen = tcount;
    Ser_done = 1'b1;
    tick(1);
    Ser_done = 1'b0;
    tick(10);
    total++;
    if (tcount != seen) begin bad++; $display("FAIL mid_quiet: got %0d toggles required 0", tcount - seen); end
  endtask

  task automatic test_collision();
    int start = tcount;
    RdData = 8'h5A; Rd_valid = 1'b1;
    ALU_out = 16'h7777; ALU_FUN = 4'b0000; ALU_out_valid = 1'b1;
    exp_q.push_back(8'h5A);
    tick(1);
    Rd_valid = 1'b0; ALU_out_valid = 1'b0;
    total += 2;
    if (Ovf !== 1'b1)     begin bad++; $display("FAIL coll_ovf: got %b required 1", Ovf); end
    if (Q_count !== 3'd1) begin bad++; $display("FAIL coll_q: got %0d required 1", Q_count); end
    wait_byte("coll_byte");
    finish_byte();
    tick(8);
    total++;
    if (tcount - start != 1) begin bad++; $display("FAIL coll_toggles: got %0d required 1", tcount - start); end
  endtask

`ifdef TX_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    pulse_rd(8'h11);
    pulse_rd(8'h22);
    wait_byte("tmo_first");
    tick(15);
    total++;
    if (Err !== 1'b0) begin bad++; $display("FAIL tmo_early: got %b required 0", Err); end
    tick(1);
    total++;
    if (Err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b required 1", Err); end
    wait_byte("tmo_next");
    finish_byte();
  endtask
`endif

  initial begin
    test_reset();
    test_register_read();
    test_arith();
    test_logic();
    test_overflow();
    test_reset_midop();
    test_collision();
`ifdef TX_TIMEOUT_EN
    test_timeout();
`endif
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
